// File: rtl/sig_verify.sv
// LDGM signature verifier: accumulates the quasi-cyclic syndrome of a received signature, counts its weight, and reports pass/fail.
// Optional feature macro SIGVER_EARLY_ABORT_EN stops the run as soon as the accumulated weight exceeds W_MAX.
module sig_verify #(
  parameter int CIRC   = 50,
  parameter int NBLK   = 196,
  parameter int SYN_W  = 4900,
  parameter int ADDR_W = 8,
  parameter int WT_W   = 14,
  parameter int W_MAX  = 1000
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [SYN_W-1:0]  syn_exp,
  input  logic              sig_valid,
  output logic              sig_ready,
  input  logic [CIRC-1:0]   sig_blk,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [SYN_W-1:0]  rom_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [WT_W-1:0]   weight
);

  localparam int NSUB  = SYN_W / CIRC;
  localparam int BC_W  = $clog2(CIRC + 1);
  localparam int PC_W  = $clog2(CIRC + 1);
  localparam int SUM_W = WT_W + PC_W;

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_FETCH, S_WAIT, S_ACC, S_CHECK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SYN_W-1:0]  acc_q, acc_d;
  logic [SYN_W-1:0]  syn_q, syn_d;
  logic [SYN_W-1:0]  colreg_q, colreg_d;
  logic [CIRC-1:0]   shreg_q, shreg_d;
  logic [ADDR_W-1:0] blk_q, blk_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [WT_W-1:0]   wt_q, wt_d;
  logic [1:0]        fc_q, fc_d;
  logic              pass_q, pass_d;
  logic              abort_q, abort_d;
  logic [SUM_W-1:0]  wt_sum;
  logic [WT_W-1:0]   wt_sat;

  function automatic logic [PC_W-1:0] popcnt(input logic [CIRC-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < CIRC; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  // Each CIRC-bit sub-block rotates toward its MSB; the MSB wraps into bit 0.
  function automatic logic [SYN_W-1:0] qc_rot(input logic [SYN_W-1:0] v);
    logic [SYN_W-1:0] r;
    r = v;
    for (int s = 0; s < NSUB; s++)
      r[s*CIRC +: CIRC] = {v[s*CIRC +: CIRC-1], v[s*CIRC + CIRC-1]};
    return r;
  endfunction

  always_comb begin
    wt_sum = SUM_W'(wt_q) + SUM_W'(popcnt(sig_blk));
    wt_sat = (wt_sum > SUM_W'({WT_W{1'b1}})) ? {WT_W{1'b1}} : wt_sum[WT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    syn_d    = syn_q;
    colreg_d = colreg_q;
    shreg_d  = shreg_q;
    blk_d    = blk_q;
    bit_d    = bit_q;
    wt_d     = wt_q;
    fc_d     = fc_q;
    pass_d   = pass_q;
    abort_d  = abort_q;
    case (state_q)
      S_IDLE: if (start) begin
        syn_d   = syn_exp;
        acc_d   = '0;
        wt_d    = '0;
        blk_d   = '0;
        fc_d    = 2'b00;
        pass_d  = 1'b0;
        abort_d = 1'b0;
        state_d = S_RECV;
      end
      S_RECV: if (sig_valid) begin
        shreg_d = sig_blk;
        wt_d    = wt_sat;
        state_d = S_FETCH;
`ifdef SIGVER_EARLY_ABORT_EN
        if (SUM_W'(wt_sat) > SUM_W'(W_MAX)) begin
          abort_d = 1'b1;
          state_d = S_CHECK;
        end
`endif
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        colreg_d = rom_dout;
        bit_d    = '0;
        state_d  = S_ACC;
      end
      S_ACC: begin
        if (shreg_q[0]) acc_d = acc_q ^ colreg_q;
        shreg_d  = shreg_q >> 1;
        colreg_d = qc_rot(colreg_q);
        bit_d    = bit_q + BC_W'(1);
        if (bit_q == BC_W'(CIRC-1)) begin
          if (blk_q == ADDR_W'(NBLK-1)) begin
            state_d = S_CHECK;
          end else begin
            blk_d   = blk_q + ADDR_W'(1);
            state_d = S_RECV;
          end
        end
      end
      S_CHECK: begin
        // An aborted run never finished its syndrome, so only weight is judged.
        fc_d[0] = !abort_q && (acc_q != syn_q);
        fc_d[1] = SUM_W'(wt_q) > SUM_W'(W_MAX);
        pass_d  = !(fc_d[0] || fc_d[1]);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      syn_q    <= '0;
      colreg_q <= '0;
      shreg_q  <= '0;
      blk_q    <= '0;
      bit_q    <= '0;
      wt_q     <= '0;
      fc_q     <= 2'b00;
      pass_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      syn_q    <= syn_d;
      colreg_q <= colreg_d;
      shreg_q  <= shreg_d;
      blk_q    <= blk_d;
      bit_q    <= bit_d;
      wt_q     <= wt_d;
      fc_q     <= fc_d;
      pass_q   <= pass_d;
      abort_q  <= abort_d;
    end
  end

  assign sig_ready = (state_q == S_RECV);
  assign rom_en    = (state_q == S_FETCH);
  assign rom_addr  = blk_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail_code = fc_q;
  assign weight    = wt_q;

endmodule

// File: tb/tb_sig_verify.sv
// Self-checking bench for sig_verify: directed vector table plus randomized runs against a direct syndrome/weight model.
module tb_sig_verify;

  localparam int C   = 8;
  localparam int N   = 12;
  localparam int S   = 32;
  localparam int AW  = 4;
  localparam int WW  = 6;
  localparam int WM  = 20;
  localparam int TOT = N * C;
  localparam int WSAT = (1 << WW) - 1;

  logic          clk, rst_b, start, sig_valid, sig_ready, rom_en, busy, done, pass;
  logic [S-1:0]  syn_exp, rom_dout;
  logic [C-1:0]  sig_blk;
  logic [AW-1:0] rom_addr;
  logic [1:0]    fail_code;
  logic [WW-1:0] weight;

  logic [S-1:0]  rom [N];

  int n_cmp = 0;
  int n_bad = 0;

  sig_verify #(.CIRC(C), .NBLK(N), .SYN_W(S), .ADDR_W(AW), .WT_W(WW), .W_MAX(WM)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .syn_exp(syn_exp),
    .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_blk(sig_blk),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code), .weight(weight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (rom_en) rom_dout <= rom[rom_addr];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Rotate every C-bit sub-block toward its MSB by r positions.
  function automatic logic [S-1:0] rot_by(input logic [S-1:0] v, input int r);
    logic [S-1:0] o;
    o = '0;
    for (int s = 0; s < S / C; s++)
      for (int k = 0; k < C; k++) o[s*C + (k + r) % C] = v[s*C + k];
    return o;
  endfunction

  function automatic logic [S-1:0] model_syn(input logic [TOT-1:0] sig);
    logic [S-1:0] a;
    a = '0;
    for (int b = 0; b < N; b++)
      for (int j = 0; j < C; j++) if (sig[b*C + j]) a ^= rot_by(rom[b], j);
    return a;
  endfunction

  task automatic model_result(input logic [TOT-1:0] sig, input logic [S-1:0] se,
                              output bit e_pass, output int e_fc, output int e_wt,
                              output int e_blocks);
    int cnt;
    bit ab;
    cnt = 0; ab = 0; e_blocks = N; e_wt = 0;
    for (int b = 0; b < N; b++) begin
      cnt += $countones(sig[b*C +: C]);
      e_wt = (cnt > WSAT) ? WSAT : cnt;
`ifdef SIGVER_EARLY_ABORT_EN
      if (e_wt > WM) begin
        ab = 1; e_blocks = b + 1;
        break;
      end
`endif
    end
    if (ab) e_fc = 2;
    else    e_fc = ((e_wt > WM) ? 2 : 0) + ((model_syn(sig) != se) ? 1 : 0);
    e_pass = (e_fc == 0);
  endtask

  task automatic run_sig(input logic [TOT-1:0] sig, input logic [S-1:0] se,
                         input bit gaps, input bit xstarts,
                         output bit r_pass, output int r_fc, output int r_wt,
                         output int r_cyc, output int r_dones, output int r_blocks,
                         output bit r_to, output bit r_held, output bit r_clr);
    int idx, gap;
    idx = 0; gap = 0; r_cyc = 0; r_dones = 0; r_to = 1; r_held = 1;
    r_pass = 0; r_fc = -1; r_wt = -1;
    @(negedge clk);
    start = 1'b1; syn_exp = se; sig_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    r_clr = (pass == 1'b0);
    for (int t = 0; t < 3000; t++) begin
      if (busy) r_cyc++;
      if (done) begin
        r_dones++; r_pass = pass; r_fc = int'(fail_code); r_wt = int'(weight); r_to = 0;
      end
      start = xstarts && busy && !done && ($urandom_range(0, 5) == 0);
      if (gaps && gap == 0 && $urandom_range(0, 3) == 0) gap = 2;
      if (done || idx >= N) sig_valid = 1'b0;
      else if (gap > 0) begin sig_valid = 1'b0; gap--; end
      else sig_valid = 1'b1;
      sig_blk = (idx < N) ? sig[idx*C +: C] : '0;
      if (sig_valid && sig_ready) idx++;
      if (!r_to) break;
      @(negedge clk);
    end
    start = 1'b0; sig_valid = 1'b0;
    r_blocks = idx;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || pass != r_pass || int'(fail_code) != r_fc || int'(weight) != r_wt)
        r_held = 0;
    end
  endtask

  task automatic check_run(input string nm, input logic [TOT-1:0] sig, input logic [S-1:0] se,
                           input bit gaps, input bit xs, input bit t_pass, input int t_fc,
                           input int t_wt);
    bit rp, to, held, clr, mp;
    int rfc, rwt, cyc, nd, nb, mfc, mwt, mb;
    model_result(sig, se, mp, mfc, mwt, mb);
    run_sig(sig, se, gaps, xs, rp, rfc, rwt, cyc, nd, nb, to, held, clr);
    chk({nm, "_timeout"}, to, 0);
    chk({nm, "_pass"}, rp, t_pass);
    chk({nm, "_fcode"}, rfc, t_fc);
    chk({nm, "_weight"}, rwt, t_wt);
    chk({nm, "_ndone"}, nd, 1);
    chk({nm, "_blocks"}, nb, mb);
    chk({nm, "_held"}, held, 1);
    chk({nm, "_pass_clr"}, clr, 1);
    if (!gaps && mb == N) chk({nm, "_cycles"}, cyc, N * (C + 3) + 2);
  endtask

  typedef struct {
    string        name;
    logic [TOT-1:0] sig;
    int           syn_mode;
    bit           exp_pass;
    int           exp_fc;
    int           exp_wt;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [TOT-1:0] sg;
    logic [S-1:0]   se;
    bit mp;
    int mfc, mwt, mb, idx, nd, dens;

    for (int b = 0; b < N; b++) rom[b] = $urandom;
    rst_b = 1'b1; start = 1'b0; sig_valid = 1'b0; sig_blk = '0; syn_exp = '0;

    sg = '0;
    vt[0] = '{"all_zero", sg, 0, 1'b1, 0, 0};
    sg[0] = 1'b1;
    vt[1] = '{"b0bit0", sg, 2, 1'b1, 0, 1};
    vt[2] = '{"b0bit0_bad", sg, 0, 1'b0, 1, 1};
    sg = '0; sg[5*C + 3] = 1'b1;
    vt[3] = '{"b5bit3_rot", sg, 3, 1'b1, 0, 1};
    sg = '0;
    for (int b = 0; b < 10; b++) begin sg[b*C] = 1'b1; sg[b*C + 4] = 1'b1; end
    sg[10*C + 7] = 1'b1;
    vt[4] = '{"overweight", sg, 1, 1'b0, 2, WM + 1};
    sg = '1;
`ifdef SIGVER_EARLY_ABORT_EN
    vt[5] = '{"all_ones", sg, 1, 1'b0, 2, 3 * C};
`else
    vt[5] = '{"all_ones", sg, 1, 1'b0, 2, WSAT};
`endif

    // Reset state, including a start presented together with reset.
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fcode", fail_code, 0);
    chk("rst_weight", weight, 0);
    chk("rst_ready", sig_ready, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    start = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      case (vt[i].syn_mode)
        0:       se = '0;
        1:       se = model_syn(vt[i].sig);
        2:       se = rom[0];
        default: se = rot_by(rom[5], 3);
      endcase
      check_run(vt[i].name, vt[i].sig, se, 0, 0, vt[i].exp_pass, vt[i].exp_fc, vt[i].exp_wt);
    end

    // Random vectors, gap-free and then with source gaps and stray starts.
    for (int r = 0; r < 8; r++) begin
      dens = $urandom_range(2, 30);
      for (int k = 0; k < TOT; k++) sg[k] = ($urandom_range(0, 99) < dens);
      se = model_syn(sg);
      if ($urandom_range(0, 1) == 1) se[$urandom_range(0, S - 1)] ^= 1'b1;
      model_result(sg, se, mp, mfc, mwt, mb);
      check_run($sformatf("rnd%0d", r), sg, se, 0, 0, mp, mfc, mwt);
      check_run($sformatf("rndgap%0d", r), sg, se, 1, 1, mp, mfc, mwt);
    end

    // Reset in the middle of a run, then a clean rerun of the single-bit vector.
    check_run("pre_rst", vt[1].sig, rom[0], 0, 0, 1'b1, 0, 1);
    @(negedge clk);
    start = 1'b1; syn_exp = '0;
    @(negedge clk);
    start = 1'b0; idx = 0;
    for (int t = 0; t < 500; t++) begin
      if (idx >= 7) break;
      sig_valid = 1'b1; sig_blk = C'($urandom);
      if (sig_ready) idx++;
      @(negedge clk);
    end
    chk("mid_rst_reached", idx, 7);
    sig_valid = 1'b0; rst_b = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", sig_ready, 0);
    chk("mid_rst_pass", pass, 0);
    chk("mid_rst_weight", weight, 0);
    rst_b = 1'b0; nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_rst_nodone", nd, 0);
    check_run("post_rst", vt[1].sig, rom[0], 0, 0, 1'b1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
